// File: rtl/ripple_count_sampler_pkg.sv
// rtl/ripple_count_sampler_pkg.sv - shared types and constants for the ripple count sampler
package ripple_count_sampler_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_STABLE_CYCLES = 2;
    // Wide enough for the largest legal STABLE_CYCLES (15)
    localparam int STAB_W            = 4;

endpackage

// File: rtl/ripple_count_sampler_sync_2ff.sv
// rtl/ripple_count_sampler_sync_2ff.sv - per-bit two-flop synchroniser, resets to all-ones
module ripple_count_sampler_sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/ripple_count_sampler.sv
// rtl/ripple_count_sampler.sv - brings a ripple down-counter value into clk, filters it, emits valid/ready transactions
module ripple_count_sampler
    import ripple_count_sampler_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_async,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_count,
    output logic             out_wrap,
    output logic             out_skip,
    output logic             overrun
);

    localparam logic [WIDTH-1:0]  ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);

    logic [WIDTH-1:0]  s2;
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              wrap_q, wrap_d;
    logic              skip_q, skip_d;
    logic              overrun_q, overrun_d;
    logic              accept, txn, txn_wrap, txn_skip;

    ripple_count_sampler_sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk    (clk),
        .resetn (reset),
        .d      (cnt_async),
        .q      (s2)
    );

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        stab_d    = stab_q;
        prev_d    = prev_q;
        valid_d   = valid_q;
        count_d   = count_q;
        wrap_d    = wrap_q;
        skip_d    = skip_q;
        overrun_d = overrun_q;
        accept    = 1'b0;
        txn       = 1'b0;

        if (s2 != cand_q) begin
            cand_d = s2;
            stab_d = STAB_W'(1);
        end else begin
            accept = (stab_q == STAB_LAST);
            if (stab_q < STAB_MAX) begin
                stab_d = stab_q + STAB_W'(1);
            end
        end

        txn_wrap = (prev_q == '0) && (cand_q == ALL_ONES);
        txn_skip = !txn_wrap && (cand_q != (prev_q - WIDTH'(1)));

        if (accept) begin
            case (state_q)
                ST_INIT: begin
                    prev_d  = cand_q;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    // A value that settles back to prev is a glitch, not a count
                    if (cand_q != prev_q) begin
                        txn    = 1'b1;
                        prev_d = cand_q;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end

        if (txn) begin
            if (!valid_q || out_ready) begin
                valid_d = 1'b1;
                count_d = cand_q;
                wrap_d  = txn_wrap;
                skip_d  = txn_skip;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_INIT;
            cand_q    <= ALL_ONES;
            stab_q    <= '0;
            prev_q    <= ALL_ONES;
            valid_q   <= 1'b0;
            count_q   <= ALL_ONES;
            wrap_q    <= 1'b0;
            skip_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            stab_q    <= stab_d;
            prev_q    <= prev_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            skip_q    <= skip_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = valid_q;
    assign out_count = count_q;
    assign out_wrap  = wrap_q;
    assign out_skip  = skip_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb/tb_ripple_count_sampler.sv - self-checking bench for ripple_count_sampler
module tb_ripple_count_sampler;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk;
    logic         reset;
    logic [W-1:0] cnt_async;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_count;
    logic         out_wrap;
    logic         out_skip;
    logic         overrun;

    int checks   = 0;
    int failures = 0;

    ripple_count_sampler #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_async (cnt_async),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_count (out_count),
        .out_wrap  (out_wrap),
        .out_skip  (out_skip),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: delay line of raw samples, run length of the seen value, last accepted value
    int pipe[$];
    int run_val, run_len;
    bit m_init;
    int m_prev;
    bit m_valid, m_wrap, m_skip, m_ovr;
    int m_count;

    task automatic model_edge();
        int  seen;
        bit  accept, is_txn, w, sk;
        if (!reset) begin
            pipe = {15, 15};
            run_val = 15; run_len = 0; m_init = 1'b1; m_prev = 15;
            m_valid = 0; m_count = 15; m_wrap = 0; m_skip = 0; m_ovr = 0;
            return;
        end
        seen = pipe.pop_front();
        pipe.push_back(int'(cnt_async));
        if (seen == run_val) begin
            if (run_len < 1000) run_len++;
        end else begin
            run_val = seen;
            run_len = 1;
        end
        accept = (run_len == S);
        is_txn = 0; w = 0; sk = 0;
        if (accept) begin
            if (m_init) begin
                m_prev = seen;
                m_init = 0;
            end else if (seen != m_prev) begin
                is_txn = 1;
                w  = (m_prev == 0) && (seen == (1 << W) - 1);
                sk = !w && (seen != ((m_prev + (1 << W) - 1) % (1 << W)));
                m_prev = seen;
            end
        end
        if (is_txn) begin
            if (!m_valid || out_ready) begin
                m_valid = 1; m_count = seen; m_wrap = w; m_skip = sk;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        if (out_valid !== m_valid || out_count !== W'(m_count) || out_wrap !== m_wrap ||
            out_skip !== m_skip || overrun !== m_ovr) begin
            failures++;
            $display("FAIL model: got v=%b c=%h w=%b s=%b o=%b expected v=%b c=%h w=%b s=%b o=%b at %0t",
                     out_valid, out_count, out_wrap, out_skip, overrun,
                     m_valid, W'(m_count), m_wrap, m_skip, m_ovr, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] val;
        int           hold;
        int           exp_txn;
        logic [W-1:0] exp_count;
        logic         exp_wrap;
        logic         exp_skip;
    } vec_t;

    vec_t vecs[10];
    int   ntx;
    logic [W-1:0] cap_count;
    logic cap_wrap, cap_skip;

    task automatic hold_value(logic [W-1:0] v, int n);
        cnt_async = v;
        for (int k = 0; k < n; k++) begin
            tick();
            if (out_valid && out_ready) begin
                ntx++;
                cap_count = out_count; cap_wrap = out_wrap; cap_skip = out_skip;
            end
        end
    endtask

    initial begin
        int hold;
        vecs[0] = '{4'hF, 10, 0, 4'hF, 1'b0, 1'b0};
        vecs[1] = '{4'hE,  8, 1, 4'hE, 1'b0, 1'b0};
        vecs[2] = '{4'hA,  1, 0, 4'h0, 1'b0, 1'b0};
        vecs[3] = '{4'hE,  8, 0, 4'h0, 1'b0, 1'b0};
        vecs[4] = '{4'hD,  8, 1, 4'hD, 1'b0, 1'b0};
        vecs[5] = '{4'h1,  8, 1, 4'h1, 1'b0, 1'b1};
        vecs[6] = '{4'h0,  8, 1, 4'h0, 1'b0, 1'b0};
        vecs[7] = '{4'hF,  8, 1, 4'hF, 1'b1, 1'b0};
        vecs[8] = '{4'hD,  8, 1, 4'hD, 1'b0, 1'b1};
        vecs[9] = '{4'h9,  8, 1, 4'h9, 1'b0, 1'b1};

        reset = 1'b0; cnt_async = 4'hF; out_ready = 1'b1;
        tick(); tick();
        check("reset_valid", int'(out_valid), 0);
        check("reset_count", int'(out_count), 15);
        check("reset_overrun", int'(overrun), 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            ntx = 0;
            hold_value(vecs[i].val, vecs[i].hold);
            check($sformatf("vec%0d_txns", i), ntx, vecs[i].exp_txn);
            if (vecs[i].exp_txn == 1 && ntx == 1) begin
                check($sformatf("vec%0d_count", i), int'(cap_count), int'(vecs[i].exp_count));
                check($sformatf("vec%0d_wrap", i), int'(cap_wrap), int'(vecs[i].exp_wrap));
                check($sformatf("vec%0d_skip", i), int'(cap_skip), int'(vecs[i].exp_skip));
            end
        end
        check("overrun_clear", int'(overrun), 0);

        // Stalled output: C is held, B is dropped
        out_ready = 1'b0;
        hold_value(4'hC, 8);
        check("stall_valid", int'(out_valid), 1);
        check("stall_count_c", int'(out_count), 12);
        hold_value(4'hB, 8);
        check("stall_still_c", int'(out_count), 12);
        check("stall_overrun", int'(overrun), 1);
        out_ready = 1'b1;
        tick();
        check("drain_valid", int'(out_valid), 0);
        ntx = 0;
        hold_value(4'hA, 8);
        check("after_drop_txns", ntx, 1);
        check("after_drop_count", int'(cap_count), 10);
        check("after_drop_skip", int'(cap_skip), 0);

        // Reset while a transaction is pending
        out_ready = 1'b0;
        hold_value(4'h8, 8);
        check("pre_reset_valid", int'(out_valid), 1);
        reset = 1'b0;
        tick();
        check("midreset_valid", int'(out_valid), 0);
        check("midreset_count", int'(out_count), 15);
        check("midreset_overrun", int'(overrun), 0);
        reset = 1'b1;
        cnt_async = 4'hF;

        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 1) == 0) cnt_async = cnt_async - 4'd1;
                else cnt_async = W'($urandom_range(0, 15));
                hold = $urandom_range(1, 6);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            reset = ($urandom_range(0, 299) != 0);
            tick();
            hold--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
